// File: rtl/vga_fml_sram.sv
// vga_fml_sram: FML burst slave (8 x 16-bit beats) backed by on-chip
// synchronous RAM, standing in for the SDRAM controller.
//
// Parameters:
//   fml_depth   - FML byte-address width
//   mem_aw      - RAM word-address width (2**mem_aw 16-bit words)
//   wait_cycles - extra cycles before ack (0..15), VGA_FML_SRAM_WAIT_EN only
//
// Ports:
//   clk_i      - clock, rising edge
//   rst_ni     - asynchronous active-low reset
//   fml_adr_i  - burst byte address, bits [3:0] ignored
//   fml_stb_i  - burst request, held until ack
//   fml_we_i   - 1 = write burst, 0 = read burst
//   fml_sel_i  - write byte enables (bit0 = [7:0], bit1 = [15:8])
//   fml_di     - write data
//   fml_ack_o  - one-cycle burst acknowledge
//   fml_do     - registered read data
//
// Optional feature macro: VGA_FML_SRAM_WAIT_EN adds a WAIT state with a
// 4-bit down-counter that delays every ack by wait_cycles cycles.
module vga_fml_sram #(
    parameter int fml_depth   = 20,
    parameter int mem_aw      = 12,
    parameter int wait_cycles = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [fml_depth-1:0] fml_adr_i,
    input  logic                 fml_stb_i,
    input  logic                 fml_we_i,
    input  logic [1:0]           fml_sel_i,
    input  logic [15:0]          fml_di,
    output logic                 fml_ack_o,
    output logic [15:0]          fml_do
);

    // Number of burst-index bits taken from the address.
    localparam int BW = mem_aw - 3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RSETUP = 3'd1,
        S_RACK   = 3'd2,
        S_RBURST = 3'd3,
        S_WACK   = 3'd4,
        S_WBURST = 3'd5
`ifdef VGA_FML_SRAM_WAIT_EN
        ,
        S_WAIT   = 3'd6
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]    beat_q;
    logic [BW-1:0] blk_q;
    logic [BW-1:0] blk_d;

`ifdef VGA_FML_SRAM_WAIT_EN
    localparam logic [3:0] WLOAD =
        4'((wait_cycles > 0) ? wait_cycles - 1 : 0);
    logic [3:0] wcnt_q;
    logic       we_q;
`endif

    // Zero-extend so that narrow buses still yield a full burst index;
    // bits above the RAM size are dropped, so addresses alias.
    logic [fml_depth+mem_aw-1:0] adr_wide;
    logic                        unused_adr;

    assign adr_wide   = {{mem_aw{1'b0}}, fml_adr_i};
    assign blk_d      = adr_wide[mem_aw:4];
    assign unused_adr = ^adr_wide;

    logic              mem_we;
    logic              rd_en;
    logic [2:0]        rd_beat;
    logic [mem_aw-1:0] wr_idx;
    logic [mem_aw-1:0] rd_idx;

    logic [15:0] mem [2**mem_aw];

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (fml_stb_i) begin
                    state_d = fml_we_i ? S_WACK : S_RSETUP;
`ifdef VGA_FML_SRAM_WAIT_EN
                    if (wait_cycles > 0) begin
                        state_d = S_WAIT;
                    end
`endif
                end
            end
`ifdef VGA_FML_SRAM_WAIT_EN
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = we_q ? S_WACK : S_RSETUP;
                end
            end
`endif
            S_RSETUP: state_d = S_RACK;
            S_RACK:   state_d = S_RBURST;
            S_RBURST: begin
                if (beat_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end
            S_WACK:   state_d = S_WBURST;
            S_WBURST: begin
                if (beat_q == 3'd7) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / RAM control decode
    always_comb begin
        fml_ack_o = 1'b0;
        mem_we    = 1'b0;
        rd_en     = 1'b0;
        rd_beat   = beat_q + 3'd1;
        unique case (state_q)
            S_RSETUP: begin
                rd_en   = 1'b1;
                rd_beat = 3'd0;
            end
            S_RACK: begin
                fml_ack_o = 1'b1;
                rd_en     = 1'b1;
            end
            // Read one word ahead; the last beat reads nothing so fml_do
            // keeps word 7 once the burst ends.
            S_RBURST: rd_en = (beat_q != 3'd7);
            S_WACK: begin
                fml_ack_o = 1'b1;
                mem_we    = 1'b1;
            end
            S_WBURST: mem_we = 1'b1;
            default: ;
        endcase
    end

    assign wr_idx = {blk_q, beat_q};
    assign rd_idx = {blk_q, rd_beat};

    // Burst bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q <= 3'd0;
            blk_q  <= '0;
`ifdef VGA_FML_SRAM_WAIT_EN
            wcnt_q <= 4'd0;
            we_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (fml_stb_i) begin
                        beat_q <= 3'd0;
                        blk_q  <= blk_d;
`ifdef VGA_FML_SRAM_WAIT_EN
                        wcnt_q <= WLOAD;
                        we_q   <= fml_we_i;
`endif
                    end
                end
`ifdef VGA_FML_SRAM_WAIT_EN
                S_WAIT: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
`endif
                S_RACK, S_RBURST, S_WACK, S_WBURST: begin
                    beat_q <= beat_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            if (fml_sel_i[0]) begin
                mem[wr_idx][7:0] <= fml_di[7:0];
            end
            if (fml_sel_i[1]) begin
                mem[wr_idx][15:8] <= fml_di[15:8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fml_do <= 16'h0000;
        end else if (rd_en) begin
            fml_do <= mem[rd_idx];
        end
    end

endmodule
